// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the sized data memory: access-size
//               encodings, the request FSM state type and the word width in
//               bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Bytes per stored word (one lane per byte, little-endian lane order)
   localparam int WORD_BYTES = 4;

   // Access-size encodings carried on the size port
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Request sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational lane logic for sized accesses. Produces the
//               byte enables and lane-replicated store data for a write, the
//               right-justified, extended load value for a read, and the
//               alignment check.
// Ports       : size      - access size (byte/half/word/reserved)
//               lane      - byte lane within the word (addr[1:0])
//               sign_ext  - sign-extend (1) or zero-extend (0) loads
//               wdata     - right-justified store data
//               mem_word  - current contents of the addressed word
//               byte_en   - lanes written by a store
//               wr_word   - store data replicated onto every lane
//               rd_ext    - load result, shifted to LSB and extended
//               misalign  - reserved size or unaligned half/word
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]            size,
   input  logic [1:0]            lane,
   input  logic                  sign_ext,
   input  logic [31:0]           wdata,
   input  logic [31:0]           mem_word,
   output logic [WORD_BYTES-1:0] byte_en,
   output logic [31:0]           wr_word,
   output logic [31:0]           rd_ext,
   output logic                  misalign
);

   // Addressed lanes moved down to bit 0; the upper bits are discarded below
   logic [31:0] w_shifted;
   assign w_shifted = mem_word >> {lane, 3'b000};

   always_comb begin
      byte_en  = '0;
      wr_word  = '0;
      rd_ext   = '0;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            byte_en = 4'b0001 << lane;
            wr_word = {4{wdata[7:0]}};
            rd_ext  = {{24{sign_ext & w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_HALF: begin
            misalign = lane[0];
            byte_en  = lane[1] ? 4'b1100 : 4'b0011;
            wr_word  = {2{wdata[15:0]}};
            rd_ext   = {{16{sign_ext & w_shifted[15]}}, w_shifted[15:0]};
         end
         SZ_WORD: begin
            misalign = (lane != 2'b00);
            byte_en  = 4'b1111;
            wr_word  = wdata;
            rd_ext   = mem_word;
         end
         default: begin
            misalign = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_sized.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_sized
// Description : Word-organised data memory with byte/half/word loads and
//               stores, a valid/ready request port, a one-cycle response
//               strobe and a configurable number of wait states.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_valid / req_ready - request handshake
//               wr_en, size, sign_ext - access type (store/load, size, ext)
//               addr, wdata           - byte address, right-justified data
//               rsp_valid             - one-cycle response strobe
//               rdata                 - load result / post-write store word
//               misalign_err          - reserved size or unaligned access
//               range_err             - word index beyond DEPTH_WORDS
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_sized
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 4000,
   parameter int WAIT_STATES = 0
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        wr_en,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        misalign_err,
   output logic        range_err
);

   localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int c_CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;

   // Request captured at accept, used when the access happens in WAIT
   logic                 r_wr_en;
   logic [1:0]           r_size;
   logic                 r_sign_ext;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;

   logic [31:0]          r_mem [DEPTH_WORDS];

   logic                 w_accept;
   logic                 w_access;
   logic                 w_wr_en;
   logic [1:0]           w_size;
   logic                 w_sign_ext;
   logic [31:0]          w_addr;
   logic [31:0]          w_wdata;
   logic [29:0]          w_word_idx;
   logic [c_IDX_W-1:0]   w_idx;
   logic                 w_range;
   logic                 w_mis;
   logic                 w_err;
   logic                 w_do_write;
   logic [31:0]          w_old;
   logic [31:0]          w_merged;
   logic [31:0]          w_rd_ext;
   logic [31:0]          w_wr_word;
   logic [WORD_BYTES-1:0] w_be;
   logic [31:0]          w_result;

   assign w_accept = req_valid && (r_state == IDLE);

   // With no wait states the access coincides with the accept edge;
   // otherwise it fires on the WAIT edge where the counter reads 1.
   assign w_access = (WAIT_STATES == 0) ? w_accept
                                        : ((r_state == WAIT) && (r_cnt == c_CNT_W'(1)));

   // Live port values are only consumed by an access in IDLE (zero wait
   // states); accesses from WAIT use the captured copy.
   assign w_wr_en    = (r_state == IDLE) ? wr_en    : r_wr_en;
   assign w_size     = (r_state == IDLE) ? size     : r_size;
   assign w_sign_ext = (r_state == IDLE) ? sign_ext : r_sign_ext;
   assign w_addr     = (r_state == IDLE) ? addr     : r_addr;
   assign w_wdata    = (r_state == IDLE) ? wdata    : r_wdata;

   assign w_word_idx = w_addr[31:2];
   assign w_range    = ({2'b00, w_word_idx} >= 32'(DEPTH_WORDS));
   assign w_idx      = w_word_idx[c_IDX_W-1:0];
   assign w_old      = r_mem[w_idx];

   dmem_lane_align u_align (
      .size     (w_size),
      .lane     (w_addr[1:0]),
      .sign_ext (w_sign_ext),
      .wdata    (w_wdata),
      .mem_word (w_old),
      .byte_en  (w_be),
      .wr_word  (w_wr_word),
      .rd_ext   (w_rd_ext),
      .misalign (w_mis)
   );

   assign w_err = w_mis | w_range;

   // rst_n gates the write so a request presented while reset is held
   // can never modify the array.
   assign w_do_write = w_access & w_wr_en & ~w_err & rst_n;

   // Post-write word returned on a store response
   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_merge
         assign w_merged[8*gi +: 8] = w_be[gi] ? w_wr_word[8*gi +: 8] : w_old[8*gi +: 8];
      end
   endgenerate

   assign w_result = w_err   ? 32'h0000_0000 :
                     w_wr_en ? w_merged      : w_rd_ext;

   // Storage array: per-lane write enables, contents never reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (w_do_write && w_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == c_CNT_W'(1)) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_wr_en    <= 1'b0;
         r_size     <= SZ_BYTE;
         r_sign_ext <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         if (w_accept) begin
            r_wr_en    <= wr_en;
            r_size     <= size;
            r_sign_ext <= sign_ext;
            r_addr     <= addr;
            r_wdata    <= wdata;
         end
         if (w_accept && (WAIT_STATES != 0)) begin
            r_cnt <= c_CNT_W'(WAIT_STATES);
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
         end
      end
   end

   // Response fields change only on an access edge and hold until the next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata        <= '0;
         misalign_err <= 1'b0;
         range_err    <= 1'b0;
      end else if (w_access) begin
         rdata        <= w_result;
         misalign_err <= w_mis;
         range_err    <= w_range;
      end
   end

endmodule
`default_nettype wire
